// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- eight-way round-robin arbiter with a programmable tenure limit.
//
// A single owner holds the grant until it drops its request or until it has
// held the resource for HOLD_MAX consecutive cycles. Hand-off to the next
// waiting requester happens on the same edge as the release (no idle cycle).
//
// Parameters:
//   HOLD_MAX     maximum grant cycles per tenure (0..255), 0 = unlimited
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   req[7:0]     request vector, bit k = requester k
//   grant[7:0]   registered one-hot grant, zero when idle
//   grant_idx    binary index of the grant bit, 0 when idle
//   grant_valid  grant is non-zero
//   timeout      one-cycle pulse after a forced (HOLD_MAX) release
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam bit         LIMIT_EN  = (HOLD_MAX != 0);
    // hold_q counts completed cycles of the tenure, so the forced edge is the
    // one where the counter reaches HOLD_MAX-1.
    localparam logic [7:0] HOLD_LAST = 8'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_e     fsm_q, fsm_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] owner_q, owner_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;

    logic [7:0] cand;
    logic [2:0] scan_start;
    logic [2:0] pos;
    logic       win_vld;
    logic [2:0] win_idx;
    logic       rel_normal;
    logic       rel_forced;

    // Candidate set: while busy the current owner is excluded and the scan
    // starts just past it, which is exactly where ptr is about to move.
    always_comb begin
        cand       = req;
        scan_start = ptr_q;
        if (fsm_q == BUSY) begin
            cand       = req & ~(8'd1 << owner_q);
            scan_start = owner_q + 3'd1;
        end
    end

    // Rotating priority scan; iterate from the lowest priority upward so the
    // last hit (highest priority) is the one that sticks.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 3'd0;
        pos     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            pos = scan_start + 3'(k);
            if (cand[pos]) begin
                win_vld = 1'b1;
                win_idx = pos;
            end
        end
    end

    assign rel_normal = (fsm_q == BUSY) && !req[owner_q];
    assign rel_forced = (fsm_q == BUSY) && LIMIT_EN && req[owner_q] && (hold_q == HOLD_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q     <= IDLE;
            ptr_q     <= 3'd0;
            owner_q   <= 3'd0;
            hold_q    <= 8'd0;
            grant_q   <= 8'd0;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d     = fsm_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (win_vld) begin
                    fsm_d   = BUSY;
                    owner_d = win_idx;
                    hold_d  = 8'd0;
                end
            end
            BUSY: begin
                if (rel_normal || rel_forced) begin
                    ptr_d     = owner_q + 3'd1;
                    timeout_d = rel_forced;
                    if (win_vld) begin
                        owner_d = win_idx;
                        hold_d  = 8'd0;
                    end else if (rel_forced) begin
                        // Nobody else waiting: owner starts a fresh tenure.
                        hold_d = 8'd0;
                    end else begin
                        fsm_d  = IDLE;
                        hold_d = 8'd0;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Output decode of the next state; the registers above make it glitch-free
    // and keep req off any output path.
    always_comb begin
        grant_d = 8'd0;
        idx_d   = 3'd0;
        valid_d = 1'b0;
        if (fsm_d == BUSY) begin
            grant_d = 8'd1 << owner_d;
            idx_d   = owner_d;
            valid_d = 1'b1;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: three instances (HOLD_MAX = 16, 4, 0) share one
// request vector; an abstract tenure model per instance predicts every cycle.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'd0;

    logic [7:0] g   [3];
    logic [2:0] gi  [3];
    logic       gv  [3];
    logic       to  [3];

    int n_checks = 0;
    int n_err    = 0;

    localparam int HV [3] = '{16, 4, 0};

    always #5 clk = ~clk;

    rr_arbiter8 #(.HOLD_MAX(16)) u_d16 (.clk(clk), .reset(reset), .req(req),
        .grant(g[0]), .grant_idx(gi[0]), .grant_valid(gv[0]), .timeout(to[0]));
    rr_arbiter8 #(.HOLD_MAX(4))  u_d4  (.clk(clk), .reset(reset), .req(req),
        .grant(g[1]), .grant_idx(gi[1]), .grant_valid(gv[1]), .timeout(to[1]));
    rr_arbiter8 #(.HOLD_MAX(0))  u_d0  (.clk(clk), .reset(reset), .req(req),
        .grant(g[2]), .grant_idx(gi[2]), .grant_valid(gv[2]), .timeout(to[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: who owns, for how many cycles --------
    int m_busy [3];
    int m_ptr  [3];
    int m_own  [3];
    int m_cyc  [3];   // grant cycles already seen in the current tenure
    int m_to   [3];

    function automatic int pick(input logic [7:0] mask, input int start);
        for (int k = 0; k < 8; k++) begin
            int p;
            p = (start + k) % 8;
            if (mask[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input logic [7:0] r);
        int w;
        bit forced;
        m_to[d] = 0;
        if (m_busy[d] == 0) begin
            w = pick(r, m_ptr[d]);
            if (w >= 0) begin
                m_busy[d] = 1; m_own[d] = w; m_cyc[d] = 1;
            end
        end else begin
            forced = r[m_own[d]] && (HV[d] != 0) && (m_cyc[d] == HV[d]);
            if (!r[m_own[d]] || forced) begin
                logic [7:0] others;
                others   = r;
                others[m_own[d]] = 1'b0;
                m_ptr[d] = (m_own[d] + 1) % 8;
                w = pick(others, m_ptr[d]);
                if (w >= 0) begin
                    m_own[d] = w; m_cyc[d] = 1;
                end else if (forced) begin
                    m_cyc[d] = 1;
                end else begin
                    m_busy[d] = 0;
                end
                m_to[d] = forced ? 1 : 0;
            end else begin
                m_cyc[d]++;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_busy[d] = 0; m_ptr[d] = 0; m_own[d] = 0; m_cyc[d] = 0; m_to[d] = 0;
            end else begin
                model_step(d, req);
            end
        end
    end

    // Every cycle, every instance, every output against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            logic [7:0] eg;
            eg = (m_busy[d] != 0) ? (8'd1 << m_own[d]) : 8'd0;
            chk($sformatf("model_grant%0d", d), 32'(g[d]), 32'(eg));
            chk($sformatf("model_idx%0d", d), 32'(gi[d]), (m_busy[d] != 0) ? 32'(m_own[d]) : 32'd0);
            chk($sformatf("model_valid%0d", d), 32'(gv[d]), 32'(m_busy[d] != 0));
            chk($sformatf("model_timeout%0d", d), 32'(to[d]), 32'(m_to[d]));
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req   = 8'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(g[0]), 32'h0);
        chk("rst_idx", 32'(gi[0]), 32'h0);
        chk("rst_valid", 32'(gv[0]), 32'h0);
        chk("rst_timeout", 32'(to[0]), 32'h0);
        reset = 1'b0;

        // Single request
        req = 8'h08;
        @(negedge clk);
        chk("single_grant", 32'(g[0]), 32'h08);
        chk("single_idx", 32'(gi[0]), 32'd3);
        chk("single_valid", 32'(gv[0]), 32'd1);
        req = 8'h00;
        @(negedge clk);
        chk("single_drop", 32'(g[0]), 32'h00);
        chk("single_drop_valid", 32'(gv[0]), 32'd0);

        // Reset asserted mid-tenure
        req = 8'h08;
        @(negedge clk);
        chk("midrst_pre", 32'(g[0]), 32'h08);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_grant", 32'(g[0]), 32'h0);
        chk("midrst_valid", 32'(gv[0]), 32'h0);
        chk("midrst_idx", 32'(gi[0]), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        req   = 8'h01;
        @(negedge clk);
        chk("midrst_after", 32'(g[0]), 32'h01);

        // Full rotation with zero-bubble hand-off
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("rot_idx%0d", i), 32'(gi[0]), 32'(i % 8));
            chk($sformatf("rot_valid%0d", i), 32'(gv[0]), 32'd1);
            req = 8'hFF & ~g[0];
        end

        // Pointer fairness
        do_reset();
        req = 8'h20;
        @(negedge clk);
        chk("fair_g5", 32'(g[0]), 32'h20);
        req = 8'h00;
        @(negedge clk);
        chk("fair_idle", 32'(g[0]), 32'h00);
        req = 8'h21;
        @(negedge clk);
        chk("fair_g0", 32'(g[0]), 32'h01);

        // Hold limit, HOLD_MAX=4, with a competitor
        do_reset();
        req = 8'h44;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("hold_g2_%0d", c), 32'(g[1]), 32'h04);
            chk($sformatf("hold_to_%0d", c), 32'(to[1]), 32'd0);
        end
        @(negedge clk);
        chk("hold_g6", 32'(g[1]), 32'h40);
        chk("hold_pulse", 32'(to[1]), 32'd1);
        @(negedge clk);
        chk("hold_pulse_end", 32'(to[1]), 32'd0);

        // Hold limit with no competitor: owner re-granted
        do_reset();
        req = 8'h04;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("regrant_g2_%0d", c), 32'(g[1]), 32'h04);
        end
        @(negedge clk);
        chk("regrant_keep", 32'(g[1]), 32'h04);
        chk("regrant_pulse", 32'(to[1]), 32'd1);
        @(negedge clk);
        chk("regrant_pulse_end", 32'(to[1]), 32'd0);

        // Disabled limit
        do_reset();
        req = 8'h12;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (g[2] !== 8'h02 || to[2] !== 1'b0) begin
                chk("nolimit_grant", 32'(g[2]), 32'h02);
                chk("nolimit_to", 32'(to[2]), 32'd0);
            end
        end
        chk("nolimit_final", 32'(g[2]), 32'h02);

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                req = 8'($urandom) & 8'($urandom);
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one downstream resource among eight requesters. It issues a registered one-hot grant together with its 3-bit binary index. The index uses the same position encoding as the team's 8-to-3 one-hot encoder: bit k maps to index k. A grant is held until the owner drops its request, or until a programmable hold limit forces rotation. Ownership hands off to the next waiting requester with no idle bubble.

## Interface
Parameters:
- HOLD_MAX, default 16: maximum consecutive cycles one grant tenure may last. Legal range 0..255; 0 disables the limit.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit k high = requester k wants the resource; held high for the whole tenure.
- grant  output  8  one-hot grant (registered); all-zero when nobody owns the resource.
- grant_idx  output  3  binary index of the set grant bit; 3'd0 when grant_valid=0.
- grant_valid  output  1  high when grant is non-zero.
- timeout  output  1  one-cycle pulse in the first cycle after a HOLD_MAX forced release.

## Operation
- State: fsm ∈ {IDLE, BUSY}; ptr[2:0] = highest-priority position; owner[2:0]; hold_cnt[7:0].
- Winner selection (combinational): scan positions ptr, ptr+1, …, ptr+7 (mod 8) over a candidate mask. The first set bit wins.
- IDLE: candidate mask = req. If the mask is non-zero, register the winner w:
  - grant = 1<<w, owner = w, hold_cnt = 0, fsm = BUSY.
  - If the mask is zero, stay in IDLE with outputs zero.
- BUSY, normal release (req[owner]=0):
  - ptr = owner+1 (mod 8).
  - Candidate mask = req with bit owner cleared, scanned from owner+1.
  - If a winner exists, grant it in the same edge (new tenure, hold_cnt=0). Otherwise grant=0 and fsm = IDLE.
- BUSY, forced release (HOLD_MAX≠0, req[owner]=1, hold_cnt == HOLD_MAX−1):
  - Same as a normal release, but timeout=1 next cycle.
  - If no other requester is pending, owner is re-granted as a new tenure (hold_cnt=0).
- BUSY, otherwise: hold grant; hold_cnt increments and saturates at 255.
- Invariants:
  - grant is always zero or one-hot.
  - grant_idx always equals the encoded grant.
  - A requester never receives a grant while its req is low at the arbitration edge.
- Wrap-around: ptr and the scan index are 3-bit and wrap 7→0 naturally.
- Simultaneous events: release and new requests on the same edge are resolved in that edge. Requests arriving mid-tenure wait; they do not preempt.

## Timing
- Reset (async, immediate): grant=0, grant_idx=0, grant_valid=0, timeout=0, fsm=IDLE, ptr=0, owner=0, hold_cnt=0.
- Reset asserted mid-tenure drops the grant immediately. After deassertion, arbitration restarts from ptr=0.
- Grant latency: req sampled high at edge n (in IDLE) → grant visible after edge n.
- Release latency: req[owner] sampled low at edge n → old grant removed and new grant present after edge n. There is zero dead cycles between owners.
- Tenure length:
  - With HOLD_MAX=H≠0 and req held, the owner sees exactly H grant cycles.
  - timeout is high for exactly the one cycle following the forced edge.
- All outputs are registered; no combinational path from req to any output.

## Test plan
- Reset mid-grant: grant=8'h08 active, assert reset asynchronously → grant=0, grant_valid=0, grant_idx=0 before the next edge. After release, req=8'h01 → grant=8'h01 one edge later.
- Single request: req=8'h08 from IDLE → after one edge grant=8'h08, grant_idx=3, grant_valid=1. Drop req → grant=0 after the next edge, fsm=IDLE.
- Full rotation: req=8'hFF, each owner drops its bit for one cycle upon grant, then re-raises it → grant_idx sequence 0,1,2,…,7,0 with no zero-grant cycles between owners.
- Pointer fairness: grant 5 then release → ptr=6. Then req=8'h21 → grant=8'h01 (index 0, not 5).
- Hold limit: HOLD_MAX=4, req[2] held with req[6] high → grant=8'h04 for exactly 4 cycles, then grant=8'h40 plus a single-cycle timeout pulse. Repeat with req[6] low → req[2] is re-granted and timeout pulses.
- Disabled limit: HOLD_MAX=0, req[1] held 300 cycles with req[4] high → grant stays 8'h02 throughout and timeout never asserts.
